// File: rtl/multicycle_ctrl_pkg.sv
// Shared encodings for the multicycle sequencer: bus modes, opcodes, states and control payload.
package multicycle_ctrl_pkg;

    localparam int unsigned OPC_W    = 4;
    localparam int unsigned ALU_OP_W = 3;
    localparam int unsigned MODE_W   = 2;
    localparam int unsigned STATE_W  = 5;

    localparam logic [MODE_W-1:0] BM_IDLE   = 2'b00;
    localparam logic [MODE_W-1:0] BM_LOAD   = 2'b01;
    localparam logic [MODE_W-1:0] BM_DRIVE  = 2'b10;
    localparam logic [MODE_W-1:0] MEM_READ  = 2'b01;
    localparam logic [MODE_W-1:0] MEM_WRITE = 2'b10;

    localparam logic [OPC_W-1:0] OPC_LD   = 4'd8;
    localparam logic [OPC_W-1:0] OPC_ST   = 4'd9;
    localparam logic [OPC_W-1:0] OPC_LI   = 4'd10;
    localparam logic [OPC_W-1:0] OPC_JZ   = 4'd11;
    localparam logic [OPC_W-1:0] OPC_HALT = 4'd15;

    // Order is visible on StateDbg.
    typedef enum logic [STATE_W-1:0] {
        S_RESET_PC, S_FETCH_MAR, S_FETCH_MEM, S_FETCH_IR, S_DECODE,
        S_ALU_A, S_ALU_B, S_ALU_WB,
        S_LD_ADDR, S_LD_MEM, S_LD_WB,
        S_ST_ADDR, S_ST_DATA, S_ST_MEM,
        S_LI_INC, S_LI_MAR, S_LI_MEM, S_LI_WB,
        S_JZ_TEST, S_JZ_LOAD, S_INCPC, S_HALT, S_FAULT
    } state_e;

    typedef struct packed {
        logic [MODE_W-1:0]   pc_bus;
        logic [MODE_W-1:0]   ir_bus;
        logic [MODE_W-1:0]   x_bus;
        logic [MODE_W-1:0]   y_bus;
        logic [MODE_W-1:0]   z_bus;
        logic [MODE_W-1:0]   mar_bus;
        logic [MODE_W-1:0]   mdr_bus;
        logic [MODE_W-1:0]   mdr_mem;
        logic [MODE_W-1:0]   mem;
        logic [MODE_W-1:0]   reg_mode;
        logic                pc_inc;
        logic                pc_reset;
        logic [ALU_OP_W-1:0] alu_op;
        logic                halted;
        logic                fault;
    } ctrl_t;

    function automatic ctrl_t ctrl_reset();
        ctrl_t c;
        c = '0;
        c.pc_reset = 1'b1;
        return c;
    endfunction

    function automatic logic is_mem_state(input state_e s);
        return (s == S_FETCH_MEM) || (s == S_LD_MEM) || (s == S_ST_MEM) || (s == S_LI_MEM);
    endfunction

    // Memory states hold until ready, or give up once the wait budget is spent.
    function automatic state_e mem_next(input state_e cur, input state_e done,
                                        input logic ready, input logic timeout);
        if (ready)        return done;
        else if (timeout) return S_FAULT;
        else              return cur;
    endfunction

endpackage

// File: rtl/mem_wait_timer.sv
// Wait-state counter for one memory access; timeout flags that the count has reached MAX_COUNT.
module mem_wait_timer #(
    parameter int unsigned MAX_COUNT = 15
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic timeout
);

    localparam int unsigned CNT_W = (MAX_COUNT < 1) ? 1 : $clog2(MAX_COUNT + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(MAX_COUNT);

    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_nxt;

    always_comb begin
        count_nxt = count_q;
        if (clr) begin
            count_nxt = '0;
        end else if (en && (count_q != CNT_MAX)) begin
            count_nxt = count_q + CNT_W'(1);
        end
    end

    // timeout is registered alongside the count so it always mirrors count_q == CNT_MAX.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q <= '0;
            timeout <= (CNT_MAX == '0);
        end else begin
            count_q <= count_nxt;
            timeout <= (count_nxt == CNT_MAX);
        end
    end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multicycle sequencer for the IDIOT datapath: fetch/decode plus per-opcode micro-sequences
// driving every bus-mode control, with memory wait handling, halt and fault.
module multicycle_ctrl
    import multicycle_ctrl_pkg::*;
#(
    parameter int unsigned WORD_W       = 16,
    parameter int unsigned REG_ADDR_W   = 6,
    parameter int unsigned MEM_WAIT_MAX = 15
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [WORD_W-1:0]     ir,
    input  logic                  BusZero,
    input  logic                  MemReady,
    output logic [1:0]            PCBusMode,
    output logic [1:0]            IRBusMode,
    output logic [1:0]            XBusMode,
    output logic [1:0]            YBusMode,
    output logic [1:0]            ZBusMode,
    output logic [1:0]            MARBusMode,
    output logic [1:0]            MDRBusMode,
    output logic [1:0]            MDRMemMode,
    output logic [1:0]            MemMode,
    output logic [1:0]            RegMode,
    output logic                  PCInc,
    output logic                  PCReset,
    output logic [2:0]            ALUOp,
    output logic [REG_ADDR_W-1:0] RegAddr,
    output logic                  Halted,
    output logic                  Fault,
    output logic [4:0]            StateDbg
);

    state_e                state_q;
    state_e                state_nxt;
    logic [OPC_W-1:0]      opc_q,  opc_nxt;
    logic [REG_ADDR_W-1:0] d_q,    d_nxt;
    logic [REG_ADDR_W-1:0] s_q,    s_nxt;
    ctrl_t                 ctrl_q, ctrl_nxt;
    logic [REG_ADDR_W-1:0] reg_addr_q, reg_addr_nxt;
    logic                  in_mem;
    logic                  wait_clr;
    logic                  wait_en;
    logic                  wait_timeout;

    assign in_mem   = is_mem_state(state_q);
    assign wait_en  = in_mem && !MemReady;
    assign wait_clr = !in_mem || MemReady;

    mem_wait_timer #(
        .MAX_COUNT (MEM_WAIT_MAX)
    ) u_wait (
        .clk     (clk),
        .reset   (reset),
        .clr     (wait_clr),
        .en      (wait_en),
        .timeout (wait_timeout)
    );

    // Instruction fields are captured only in DECODE; ir is ignored everywhere else.
    always_comb begin
        opc_nxt = opc_q;
        d_nxt   = d_q;
        s_nxt   = s_q;
        if (state_q == S_DECODE) begin
            opc_nxt = ir[WORD_W-1 -: OPC_W];
            d_nxt   = ir[2*REG_ADDR_W-1 : REG_ADDR_W];
            s_nxt   = ir[REG_ADDR_W-1:0];
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q    <= S_RESET_PC;
            opc_q      <= '0;
            d_q        <= '0;
            s_q        <= '0;
            ctrl_q     <= ctrl_reset();
            reg_addr_q <= '0;
        end else begin
            state_q    <= state_nxt;
            opc_q      <= opc_nxt;
            d_q        <= d_nxt;
            s_q        <= s_nxt;
            ctrl_q     <= ctrl_nxt;
            reg_addr_q <= reg_addr_nxt;
        end
    end

    always_comb begin
        state_nxt = state_q;
        case (state_q)
            S_RESET_PC:  state_nxt = S_FETCH_MAR;
            S_FETCH_MAR: state_nxt = S_FETCH_MEM;
            S_FETCH_MEM: state_nxt = mem_next(state_q, S_FETCH_IR, MemReady, wait_timeout);
            S_FETCH_IR:  state_nxt = S_DECODE;
            S_DECODE: begin
                if (!opc_nxt[OPC_W-1]) begin
                    state_nxt = S_ALU_A;
                end else begin
                    case (opc_nxt)
                        OPC_LD:   state_nxt = S_LD_ADDR;
                        OPC_ST:   state_nxt = S_ST_ADDR;
                        OPC_LI:   state_nxt = S_LI_INC;
                        OPC_JZ:   state_nxt = S_JZ_TEST;
                        OPC_HALT: state_nxt = S_HALT;
                        default:  state_nxt = S_FAULT;
                    endcase
                end
            end
            S_ALU_A:     state_nxt = S_ALU_B;
            S_ALU_B:     state_nxt = S_ALU_WB;
            S_ALU_WB:    state_nxt = S_INCPC;
            S_LD_ADDR:   state_nxt = S_LD_MEM;
            S_LD_MEM:    state_nxt = mem_next(state_q, S_LD_WB, MemReady, wait_timeout);
            S_LD_WB:     state_nxt = S_INCPC;
            S_ST_ADDR:   state_nxt = S_ST_DATA;
            S_ST_DATA:   state_nxt = S_ST_MEM;
            S_ST_MEM:    state_nxt = mem_next(state_q, S_INCPC, MemReady, wait_timeout);
            S_LI_INC:    state_nxt = S_LI_MAR;
            S_LI_MAR:    state_nxt = S_LI_MEM;
            S_LI_MEM:    state_nxt = mem_next(state_q, S_LI_WB, MemReady, wait_timeout);
            S_LI_WB:     state_nxt = S_INCPC;
            S_JZ_TEST:   state_nxt = BusZero ? S_JZ_LOAD : S_INCPC;
            S_JZ_LOAD:   state_nxt = S_FETCH_MAR;
            S_INCPC:     state_nxt = S_FETCH_MAR;
            S_HALT:      state_nxt = S_HALT;
            S_FAULT:     state_nxt = S_FAULT;
            default:     state_nxt = S_FAULT;
        endcase
    end

    // Controls are decoded from the upcoming state so the registered outputs line up with state_q.
    always_comb begin
        ctrl_nxt        = '0;
        reg_addr_nxt    = '0;
        ctrl_nxt.alu_op = opc_nxt[ALU_OP_W-1:0];
        case (state_nxt)
            S_RESET_PC: ctrl_nxt.pc_reset = 1'b1;
            S_FETCH_MAR, S_LI_MAR: begin
                ctrl_nxt.pc_bus  = BM_DRIVE;
                ctrl_nxt.mar_bus = BM_LOAD;
            end
            S_FETCH_MEM, S_LD_MEM, S_LI_MEM: begin
                ctrl_nxt.mem     = MEM_READ;
                ctrl_nxt.mdr_mem = BM_LOAD;
            end
            S_FETCH_IR: begin
                ctrl_nxt.mdr_bus = BM_DRIVE;
                ctrl_nxt.ir_bus  = BM_LOAD;
            end
            S_ALU_A: begin
                ctrl_nxt.reg_mode = BM_DRIVE;
                ctrl_nxt.x_bus    = BM_LOAD;
                reg_addr_nxt      = d_nxt;
            end
            S_ALU_B: begin
                ctrl_nxt.reg_mode = BM_DRIVE;
                ctrl_nxt.y_bus    = BM_LOAD;
                reg_addr_nxt      = s_nxt;
            end
            S_ALU_WB: begin
                ctrl_nxt.z_bus    = BM_DRIVE;
                ctrl_nxt.reg_mode = BM_LOAD;
                reg_addr_nxt      = d_nxt;
            end
            S_LD_ADDR: begin
                ctrl_nxt.reg_mode = BM_DRIVE;
                ctrl_nxt.mar_bus  = BM_LOAD;
                reg_addr_nxt      = s_nxt;
            end
            S_LD_WB, S_LI_WB: begin
                ctrl_nxt.mdr_bus  = BM_DRIVE;
                ctrl_nxt.reg_mode = BM_LOAD;
                reg_addr_nxt      = d_nxt;
            end
            S_ST_ADDR: begin
                ctrl_nxt.reg_mode = BM_DRIVE;
                ctrl_nxt.mar_bus  = BM_LOAD;
                reg_addr_nxt      = d_nxt;
            end
            S_ST_DATA: begin
                ctrl_nxt.reg_mode = BM_DRIVE;
                ctrl_nxt.mdr_bus  = BM_LOAD;
                reg_addr_nxt      = s_nxt;
            end
            S_ST_MEM: begin
                ctrl_nxt.mdr_mem = BM_DRIVE;
                ctrl_nxt.mem     = MEM_WRITE;
            end
            S_LI_INC, S_INCPC: ctrl_nxt.pc_inc = 1'b1;
            S_JZ_TEST: begin
                ctrl_nxt.reg_mode = BM_DRIVE;
                reg_addr_nxt      = s_nxt;
            end
            S_JZ_LOAD: begin
                ctrl_nxt.reg_mode = BM_DRIVE;
                ctrl_nxt.pc_bus   = BM_LOAD;
                reg_addr_nxt      = d_nxt;
            end
            S_HALT:  ctrl_nxt.halted = 1'b1;
            S_FAULT: ctrl_nxt.fault  = 1'b1;
            default: ;
        endcase
        // ALUOp is held only across the ALU micro-sequence.
        if (!((state_nxt == S_ALU_A) || (state_nxt == S_ALU_B) || (state_nxt == S_ALU_WB))) begin
            ctrl_nxt.alu_op = '0;
        end
    end

    assign PCBusMode  = ctrl_q.pc_bus;
    assign IRBusMode  = ctrl_q.ir_bus;
    assign XBusMode   = ctrl_q.x_bus;
    assign YBusMode   = ctrl_q.y_bus;
    assign ZBusMode   = ctrl_q.z_bus;
    assign MARBusMode = ctrl_q.mar_bus;
    assign MDRBusMode = ctrl_q.mdr_bus;
    assign MDRMemMode = ctrl_q.mdr_mem;
    assign MemMode    = ctrl_q.mem;
    assign RegMode    = ctrl_q.reg_mode;
    assign PCInc      = ctrl_q.pc_inc;
    assign PCReset    = ctrl_q.pc_reset;
    assign ALUOp      = ctrl_q.alu_op;
    assign RegAddr    = reg_addr_q;
    assign Halted     = ctrl_q.halted;
    assign Fault      = ctrl_q.fault;
    assign StateDbg   = state_q;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Bench for multicycle_ctrl: latency table, directed corner sequences and a randomized
// instruction stream checked cycle by cycle against a transfer-level model.
module tb_multicycle_ctrl;

    localparam int MAXW = 15;

    localparam int S_RESET = 0,  S_FMAR = 1,  S_FMEM = 2,   S_FIR = 3,   S_DEC = 4;
    localparam int S_ALUA  = 5,  S_ALUB = 6,  S_ALUWB = 7;
    localparam int S_LDA   = 8,  S_LDM  = 9,  S_LDWB = 10;
    localparam int S_STA   = 11, S_STD  = 12, S_STM  = 13;
    localparam int S_LII   = 14, S_LIMAR = 15, S_LIM = 16, S_LIWB = 17;
    localparam int S_JZT   = 18, S_JZL  = 19, S_INC  = 20, S_HALT = 21, S_FAULT = 22;

    typedef enum int {U_NONE, U_PC, U_IR, U_X, U_Y, U_Z, U_MAR, U_MDR, U_REG} unit_e;

    typedef struct packed {
        logic [1:0] pcb, irb, xb, yb, zb, marb, mdrb, mdrm, mem, regm;
        logic       pcinc, pcrst;
        logic [2:0] alu;
        logic [5:0] ra;
        logic       halted, fault;
        logic [4:0] st;
    } exp_t;

    typedef struct {
        exp_t        e;
        logic        mr;
        logic        bz;
        logic [15:0] w;
    } cyc_t;

    typedef struct {
        logic [15:0] w;
        int          waits;
        logic        bz;
        int          lat;
    } lat_vec_t;

    logic        clk, reset, BusZero, MemReady;
    logic [15:0] ir;
    logic [1:0]  PCBusMode, IRBusMode, XBusMode, YBusMode, ZBusMode;
    logic [1:0]  MARBusMode, MDRBusMode, MDRMemMode, MemMode, RegMode;
    logic        PCInc, PCReset, Halted, Fault;
    logic [2:0]  ALUOp;
    logic [5:0]  RegAddr;
    logic [4:0]  StateDbg;

    int   checks = 0;
    int   errors = 0;
    cyc_t plan[$];

    multicycle_ctrl #(.WORD_W(16), .REG_ADDR_W(6), .MEM_WAIT_MAX(MAXW)) dut (
        .clk(clk), .reset(reset), .ir(ir), .BusZero(BusZero), .MemReady(MemReady),
        .PCBusMode(PCBusMode), .IRBusMode(IRBusMode), .XBusMode(XBusMode),
        .YBusMode(YBusMode), .ZBusMode(ZBusMode), .MARBusMode(MARBusMode),
        .MDRBusMode(MDRBusMode), .MDRMemMode(MDRMemMode), .MemMode(MemMode),
        .RegMode(RegMode), .PCInc(PCInc), .PCReset(PCReset), .ALUOp(ALUOp),
        .RegAddr(RegAddr), .Halted(Halted), .Fault(Fault), .StateDbg(StateDbg)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    // ---------------- model: each step is a bus transfer or strobe ----------------
    function automatic exp_t only(input int st);
        exp_t e;
        e = '0;
        e.st = 5'(st);
        return e;
    endfunction

    function automatic exp_t set_bus(input exp_t e, input unit_e u, input logic [1:0] m);
        exp_t r;
        r = e;
        case (u)
            U_PC:    r.pcb  = m;
            U_IR:    r.irb  = m;
            U_X:     r.xb   = m;
            U_Y:     r.yb   = m;
            U_Z:     r.zb   = m;
            U_MAR:   r.marb = m;
            U_MDR:   r.mdrb = m;
            U_REG:   r.regm = m;
            default: ;
        endcase
        return r;
    endfunction

    function automatic exp_t xfer(input int st, input unit_e src, input unit_e dst, input logic [5:0] ra);
        exp_t e;
        e = only(st);
        e = set_bus(e, src, 2'b10);
        e = set_bus(e, dst, 2'b01);
        if (src == U_REG || dst == U_REG) e.ra = ra;
        return e;
    endfunction

    function automatic exp_t memx(input int st, input bit wr);
        exp_t e;
        e = only(st);
        e.mem  = wr ? 2'b10 : 2'b01;
        e.mdrm = wr ? 2'b10 : 2'b01;
        return e;
    endfunction

    task automatic push_full(input exp_t e, input logic mr, input logic bz, input logic [15:0] w);
        cyc_t c;
        c.e = e; c.mr = mr; c.bz = bz; c.w = w;
        plan.push_back(c);
    endtask

    task automatic push(input exp_t e);
        push_full(e, 1'($urandom), 1'($urandom), 16'($urandom));
    endtask

    task automatic push_mr(input exp_t e, input logic mr);
        push_full(e, mr, 1'($urandom), 16'($urandom));
    endtask

    task automatic push_reset_entry();
        exp_t e;
        e = only(S_RESET);
        e.pcrst = 1'b1;
        push(e);
    endtask

    task automatic fault_tail();
        exp_t e;
        e = only(S_FAULT);
        e.fault = 1'b1;
        repeat (5) push(e);
    endtask

    task automatic mem_phase(input exp_t e, input int waits, output bit flt);
        flt = (waits > MAXW);
        if (flt) begin
            repeat (MAXW + 1) push_mr(e, 1'b0);
        end else begin
            repeat (waits) push_mr(e, 1'b0);
            push_mr(e, 1'b1);
        end
    endtask

    task automatic gen_instr(input logic [15:0] w, input int wf, input int wo, input logic bz, output bit stop);
        logic [3:0] op;
        logic [5:0] d, s;
        exp_t       e;
        bit         flt;
        op = w[15:12]; d = w[11:6]; s = w[5:0]; stop = 1'b0;
        push(xfer(S_FMAR, U_PC, U_MAR, 6'd0));
        mem_phase(memx(S_FMEM, 1'b0), wf, flt);
        if (flt) begin fault_tail(); stop = 1'b1; return; end
        push(xfer(S_FIR, U_MDR, U_IR, 6'd0));
        push_full(only(S_DEC), 1'($urandom), 1'($urandom), w);
        if (op < 4'd8) begin
            e = xfer(S_ALUA, U_REG, U_X, d);  e.alu = op[2:0]; push(e);
            e = xfer(S_ALUB, U_REG, U_Y, s);  e.alu = op[2:0]; push(e);
            e = xfer(S_ALUWB, U_Z, U_REG, d); e.alu = op[2:0]; push(e);
        end else if (op == 4'd8) begin
            push(xfer(S_LDA, U_REG, U_MAR, s));
            mem_phase(memx(S_LDM, 1'b0), wo, flt);
            if (flt) begin fault_tail(); stop = 1'b1; return; end
            push(xfer(S_LDWB, U_MDR, U_REG, d));
        end else if (op == 4'd9) begin
            push(xfer(S_STA, U_REG, U_MAR, d));
            push(xfer(S_STD, U_REG, U_MDR, s));
            mem_phase(memx(S_STM, 1'b1), wo, flt);
            if (flt) begin fault_tail(); stop = 1'b1; return; end
        end else if (op == 4'd10) begin
            e = only(S_LII); e.pcinc = 1'b1; push(e);
            push(xfer(S_LIMAR, U_PC, U_MAR, 6'd0));
            mem_phase(memx(S_LIM, 1'b0), wo, flt);
            if (flt) begin fault_tail(); stop = 1'b1; return; end
            push(xfer(S_LIWB, U_MDR, U_REG, d));
        end else if (op == 4'd11) begin
            push_full(xfer(S_JZT, U_REG, U_NONE, s), 1'($urandom), bz, 16'($urandom));
            if (bz) begin
                push(xfer(S_JZL, U_REG, U_PC, d));
                return;
            end
        end else if (op == 4'd15) begin
            e = only(S_HALT); e.halted = 1'b1;
            repeat (20) push(e);
            stop = 1'b1;
            return;
        end else begin
            fault_tail();
            stop = 1'b1;
            return;
        end
        e = only(S_INC); e.pcinc = 1'b1; push(e);
    endtask

    // ---------------- checking helpers ----------------
    function automatic exp_t sample();
        exp_t g;
        g.pcb = PCBusMode;  g.irb = IRBusMode;  g.xb = XBusMode;    g.yb = YBusMode;
        g.zb = ZBusMode;    g.marb = MARBusMode; g.mdrb = MDRBusMode; g.mdrm = MDRMemMode;
        g.mem = MemMode;    g.regm = RegMode;   g.pcinc = PCInc;    g.pcrst = PCReset;
        g.alu = ALUOp;      g.ra = RegAddr;     g.halted = Halted;  g.fault = Fault;
        g.st = StateDbg;
        return g;
    endfunction

    task automatic chk(input string tag, input int idx, input exp_t exp);
        exp_t got;
        got = sample();
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s[%0d]: state got %0d want %0d, outputs got %h want %h",
                     tag, idx, got.st, exp.st, got, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int idx, input int got, input int exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s[%0d]: got %0d want %0d", tag, idx, got, exp);
        end
    endtask

    task automatic run_plan(input string tag);
        foreach (plan[i]) begin
            chk(tag, i, plan[i].e);
            MemReady = plan[i].mr;
            BusZero  = plan[i].bz;
            ir       = plan[i].w;
            @(negedge clk);
        end
        plan.delete();
    endtask

    // Asserted away from the clock edge so the clear must be asynchronous.
    task automatic do_reset(input string tag);
        exp_t e;
        reset = 1'b0;
        #1;
        e = only(S_RESET);
        e.pcrst = 1'b1;
        chk(tag, 0, e);
        @(negedge clk);
        reset = 1'b1;
    endtask

    function automatic bit st_is_mem(input logic [4:0] s);
        return (int'(s) == S_FMEM) || (int'(s) == S_LDM) || (int'(s) == S_STM) || (int'(s) == S_LIM);
    endfunction

    // Cycles from FETCH_MAR to the next FETCH_MAR, MemReady held low for `waits` cycles per access.
    task automatic measure(input logic [15:0] w, input int waits, input logic bz, output int lat);
        int wc;
        wc = 0;
        lat = 0;
        do begin
            ir = w;
            BusZero = bz;
            if (st_is_mem(StateDbg) && wc < waits) begin
                MemReady = 1'b0;
                wc++;
            end else begin
                MemReady = 1'b1;
                wc = 0;
            end
            @(negedge clk);
            lat++;
        end while (int'(StateDbg) != S_FMAR && lat < 200);
    endtask

    function automatic int rand_wait();
        int r;
        r = int'($urandom_range(0, 9));
        if (r < 6) return 0;
        if (r < 9) return int'($urandom_range(1, 4));
        return MAXW;
    endfunction

    lat_vec_t tbl[13];

    initial begin
        bit   stop;
        int   lat;
        exp_t e;

        tbl[0]  = '{16'h0045, 0,  1'b0, 8};
        tbl[1]  = '{16'h7FFF, 0,  1'b1, 8};
        tbl[2]  = '{16'h30C2, 1,  1'b0, 9};
        tbl[3]  = '{16'h8083, 0,  1'b0, 8};
        tbl[4]  = '{16'h8083, 2,  1'b0, 12};
        tbl[5]  = '{16'h9042, 0,  1'b0, 8};
        tbl[6]  = '{16'h9042, 3,  1'b1, 14};
        tbl[7]  = '{16'hA080, 0,  1'b0, 9};
        tbl[8]  = '{16'hA080, 1,  1'b0, 11};
        tbl[9]  = '{16'hB045, 0,  1'b1, 6};
        tbl[10] = '{16'hB045, 0,  1'b0, 6};
        tbl[11] = '{16'hB045, 1,  1'b1, 7};
        tbl[12] = '{16'h8083, 15, 1'b0, 38};

        reset = 1'b0; MemReady = 1'b1; BusZero = 1'b0; ir = 16'h0000;
        @(negedge clk);

        // Latency table.
        do_reset("reset");
        @(negedge clk);
        chk_int("fetch_after_reset", 0, int'(StateDbg), S_FMAR);
        for (int i = 0; i < 13; i++) begin
            measure(tbl[i].w, tbl[i].waits, tbl[i].bz, lat);
            chk_int("latency", i, lat, tbl[i].lat);
        end

        // Directed mix: ADD, LD with 3 waits, LI, JZ taken/not, ST with waits.
        do_reset("reset_dir");
        push_reset_entry();
        gen_instr(16'h0045, 0, 0, 1'b0, stop);
        gen_instr(16'h80C1, 0, 3, 1'b0, stop);
        gen_instr(16'hA080, 0, 0, 1'b0, stop);
        gen_instr(16'hB105, 0, 0, 1'b1, stop);
        gen_instr(16'hB105, 0, 0, 1'b0, stop);
        gen_instr(16'h91C9, 1, 2, 1'b0, stop);
        run_plan("directed");

        // LD with MemReady low past the budget.
        do_reset("reset_tmo");
        push_reset_entry();
        gen_instr(16'h80C1, 0, MAXW + 1, 1'b0, stop);
        run_plan("ld_timeout");

        do_reset("reset_halt");
        push_reset_entry();
        gen_instr(16'hF000, 0, 0, 1'b0, stop);
        run_plan("halt");

        do_reset("reset_op13");
        push_reset_entry();
        gen_instr(16'hD000, 0, 0, 1'b0, stop);
        run_plan("op13_fault");

        // Reset during ST_MEM, then a maximal-wait load must not inherit the old count.
        do_reset("reset_st");
        push_reset_entry();
        push(xfer(S_FMAR, U_PC, U_MAR, 6'd0));
        push_mr(memx(S_FMEM, 1'b0), 1'b1);
        push(xfer(S_FIR, U_MDR, U_IR, 6'd0));
        push_full(only(S_DEC), 1'b1, 1'b0, 16'h91C9);
        push(xfer(S_STA, U_REG, U_MAR, 6'd7));
        push(xfer(S_STD, U_REG, U_MDR, 6'd9));
        push_mr(memx(S_STM, 1'b1), 1'b0);
        push_mr(memx(S_STM, 1'b1), 1'b0);
        run_plan("st_pre_reset");
        chk_int("in_st_mem", 0, int'(StateDbg), S_STM);
        do_reset("reset_mid_st");
        push_reset_entry();
        gen_instr(16'h80C1, MAXW, MAXW, 1'b0, stop);
        run_plan("ld_after_reset");

        // Randomized instruction stream.
        do_reset("reset_rand");
        push_reset_entry();
        for (int i = 0; i < 150; i++) begin
            logic [15:0] w;
            w = {4'($urandom_range(0, 11)), 12'($urandom)};
            gen_instr(w, rand_wait(), rand_wait(), 1'($urandom), stop);
            if (stop) break;
        end
        run_plan("random");

        e = only(S_FMAR);
        e = set_bus(e, U_PC, 2'b10);
        e = set_bus(e, U_MAR, 2'b01);
        chk("random_end", 0, e);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
